// File: rtl/present_pkg.sv
// =============================================================================
// Module      : present_pkg
// Description : Shared widths, S-box table, pLayer mapping and FSM encoding
//               for the PRESENT-80 encryption core.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package present_pkg;

    localparam int BLOCK_W = 64;
    localparam int KEY_W   = 80;
    localparam int RC_W    = 5;

    // Nibble x of this constant is S(x): C 5 6 B 9 0 A D 3 E F 8 4 7 1 2
    localparam logic [63:0] SBOX_TABLE = 64'h21748FE3DA09B65C;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        return SBOX_TABLE[4*x +: 4];
    endfunction

    // Destination bit of source bit i in the pLayer
    function automatic int player_pos(input int i);
        return (i == 63) ? 63 : (16 * i) % 63;
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_schedule.sv
// =============================================================================
// Module      : key_schedule
// Description : PRESENT-80 key register update: rotate left 61, S-box the
//               top nibble, XOR the round counter into bits 19:15.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module key_schedule
    import present_pkg::*;
(
    input  logic [KEY_W-1:0] i_key,
    input  logic [RC_W-1:0]  i_rc,
    output logic [KEY_W-1:0] o_key
);

    logic [KEY_W-1:0] w_rot;

    assign w_rot = {i_key[18:0], i_key[79:19]};
    assign o_key = {sbox4(w_rot[79:76]), w_rot[75:20], w_rot[19:15] ^ i_rc, w_rot[14:0]};

endmodule

`default_nettype wire

// File: rtl/present80_enc_core_round.sv
// =============================================================================
// Module      : present_round
// Description : Combinational PRESENT sLayer followed by pLayer on the
//               64-bit state; round-key mixing is done by the caller.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module present_round
    import present_pkg::*;
(
    input  logic [BLOCK_W-1:0] i_state,
    output logic [BLOCK_W-1:0] o_state
);

    logic [BLOCK_W-1:0] w_sub;

    generate
        for (genvar gi = 0; gi < BLOCK_W / 4; gi++) begin : g_slayer
            assign w_sub[4*gi +: 4] = sbox4(i_state[4*gi +: 4]);
        end
        for (genvar gb = 0; gb < BLOCK_W; gb++) begin : g_player
            assign o_state[player_pos(gb)] = w_sub[gb];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/present80_enc_core.sv
// =============================================================================
// Module      : present80_enc_core
// Description : Iterative PRESENT-80 encryptor, one round per clock, with
//               valid/ready on both sides. Define PRESENT_ABORT_EN to add
//               the abort input.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module present80_enc_core
    import present_pkg::*;
#(
    parameter int ROUNDS = 31
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] pt,
    input  logic [KEY_W-1:0]   key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] ct
`ifdef PRESENT_ABORT_EN
    ,
    input  logic               abort
`endif
);

    localparam logic [RC_W-1:0] c_last_rc = RC_W'(ROUNDS);
    localparam logic [RC_W-1:0] c_first_rc = RC_W'(1);

    state_e             fsm_q, fsm_d;
    logic [BLOCK_W-1:0] blk_q, blk_d;
    logic [KEY_W-1:0]   rk_q, rk_d;
    logic [RC_W-1:0]    rc_q, rc_d;
    logic [BLOCK_W-1:0] ct_q, ct_d;
    logic               out_valid_q, out_valid_d;

    logic [BLOCK_W-1:0] w_round_in;
    logic [BLOCK_W-1:0] w_round_out;
    logic [KEY_W-1:0]   w_key_next;

    assign w_round_in = blk_q ^ rk_q[KEY_W-1:KEY_W-BLOCK_W];

    present_round u_round (
        .i_state (w_round_in),
        .o_state (w_round_out)
    );

    key_schedule u_key_schedule (
        .i_key (rk_q),
        .i_rc  (rc_q),
        .o_key (w_key_next)
    );

    always_comb begin
        fsm_d       = fsm_q;
        blk_d       = blk_q;
        rk_d        = rk_q;
        rc_d        = rc_q;
        ct_d        = ct_q;
        out_valid_d = out_valid_q;

        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    blk_d = pt;
                    rk_d  = key;
                    rc_d  = c_first_rc;
                    fsm_d = RUN;
                end
            end
            RUN: begin
                blk_d = w_round_out;
                rk_d  = w_key_next;
                rc_d  = rc_q + c_first_rc;
                // Final whitening uses the key produced on this same edge
                if (rc_q == c_last_rc) begin
                    rc_d        = c_first_rc;
                    ct_d        = w_round_out ^ w_key_next[KEY_W-1:KEY_W-BLOCK_W];
                    out_valid_d = 1'b1;
                    fsm_d       = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = IDLE;
                end
            end
            default: begin
                fsm_d       = IDLE;
                out_valid_d = 1'b0;
            end
        endcase

`ifdef PRESENT_ABORT_EN
        if (abort && (fsm_q != IDLE)) begin
            fsm_d       = IDLE;
            blk_d       = blk_q;
            rk_d        = rk_q;
            rc_d        = c_first_rc;
            ct_d        = ct_q;
            out_valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            blk_q       <= '0;
            rk_q        <= '0;
            rc_q        <= c_first_rc;
            ct_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            blk_q       <= blk_d;
            rk_q        <= rk_d;
            rc_q        <= rc_d;
            ct_q        <= ct_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = out_valid_q;
    assign ct        = ct_q;

endmodule

`default_nettype wire

// File: tb/tb_present80_enc_core.sv
// =============================================================================
// Module      : tb_present80_enc_core
// Description : Self-checking bench for present80_enc_core: known-answer and
//               random vectors against a behavioural PRESENT-80 model.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_present80_enc_core;

    localparam int ROUNDS = 31;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] pt;
    logic [79:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] ct;
`ifdef PRESENT_ABORT_EN
    logic        abort;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] last_ct  = '0;

    always #5 clk = ~clk;

    present80_enc_core #(.ROUNDS(ROUNDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pt        (pt),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ct        (ct)
`ifdef PRESENT_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    task automatic check_value(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Textbook PRESENT-80: addRoundKey, S-box every nibble, move bit i to 16i mod 63
    function automatic logic [63:0] ref_encrypt(input logic [63:0] p, input logic [79:0] k);
        logic [3:0]  sb [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                 4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
        logic [63:0] s, t;
        logic [79:0] kk;
        logic [4:0]  rc;
        s  = p;
        kk = k;
        for (int r = 1; r <= ROUNDS; r++) begin
            s = s ^ kk[79:16];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = sb[s[4*n +: 4]];
            t = '0;
            for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (16 * i) % 63] = s[i];
            s  = t;
            rc = 5'(r);
            kk = {kk[18:0], kk[79:19]};
            kk[79:76] = sb[kk[79:76]];
            kk[19:15] = kk[19:15] ^ rc;
        end
        return s ^ kk[79:16];
    endfunction

    // Called #1 after a rising edge with the core idle; returns #1 after the accept edge
    task automatic send(input string tag, input logic [63:0] p, input logic [79:0] k);
        pt       = p;
        key      = k;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        pt       = {$urandom(), $urandom()};
        key      = {$urandom(), $urandom(), 16'($urandom())};
        check_value({tag, "_busy_in_ready"}, 80'(in_ready), 80'd0);
    endtask

    task automatic wait_done(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_value({tag, "_latency"}, 80'(lat), 80'(ROUNDS));
    endtask

    task automatic handoff(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_value({tag, "_post_out_valid"}, 80'(out_valid), 80'd0);
        check_value({tag, "_post_in_ready"}, 80'(in_ready), 80'd1);
    endtask

    task automatic do_vector(input string tag, input logic [63:0] p, input logic [79:0] k,
                             input logic [63:0] exp);
        send(tag, p, k);
        wait_done(tag);
        check_value({tag, "_ct"}, 80'(ct), 80'(exp));
        last_ct = exp;
        handoff(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] rp, hold_ct;
        logic [79:0] rk;
        int          spur;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pt        = '0;
        key       = '0;
`ifdef PRESENT_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_in_ready", 80'(in_ready), 80'd1);
        check_value("rst_out_valid", 80'(out_valid), 80'd0);
        check_value("rst_ct", 80'(ct), 80'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_vector("kat1", 64'h0, 80'h0, 64'h5579C1387B228445);
        do_vector("kat2", 64'h0, {80{1'b1}}, 64'hE72C46C0F5945049);
        do_vector("kat3", {64{1'b1}}, 80'h0, 64'hA112FFC72F68417B);
        do_vector("kat4", {64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2);

        // Backpressure: result held while in_valid pulses are ignored
        rp = {$urandom(), $urandom()};
        rk = {$urandom(), $urandom(), 16'($urandom())};
        send("bp", rp, rk);
        wait_done("bp");
        hold_ct = ct;
        check_value("bp_ct", 80'(ct), 80'(ref_encrypt(rp, rk)));
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            pt       = {$urandom(), $urandom()};
            @(posedge clk);
            #1;
            check_value("bp_hold_ct", 80'(ct), 80'(hold_ct));
            check_value("bp_hold_valid", 80'(out_valid), 80'd1);
            check_value("bp_hold_in_ready", 80'(in_ready), 80'd0);
        end
        in_valid = 1'b0;
        handoff("bp");
        last_ct = hold_ct;

        // Reset during round 15
        send("mid_rst", {$urandom(), $urandom()}, {$urandom(), $urandom(), 16'($urandom())});
        repeat (14) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_value("mid_rst_in_ready", 80'(in_ready), 80'd1);
        check_value("mid_rst_out_valid", 80'(out_valid), 80'd0);
        check_value("mid_rst_ct", 80'(ct), 80'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        spur  = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) spur++;
        end
        check_value("mid_rst_no_pulse", 80'(spur), 80'd0);
        last_ct = '0;
        rp = {$urandom(), $urandom()};
        rk = {$urandom(), $urandom(), 16'($urandom())};
        do_vector("post_rst", rp, rk, ref_encrypt(rp, rk));

        for (int v = 0; v < 6; v++) begin
            rp = {$urandom(), $urandom()};
            rk = {$urandom(), $urandom(), 16'($urandom())};
            do_vector($sformatf("rand%0d", v), rp, rk, ref_encrypt(rp, rk));
        end

`ifdef PRESENT_ABORT_EN
        // Abort during round 10: back to idle, ct untouched, no late result
        send("abort_run", {$urandom(), $urandom()}, {$urandom(), $urandom(), 16'($urandom())});
        repeat (9) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check_value("abort_in_ready", 80'(in_ready), 80'd1);
        check_value("abort_out_valid", 80'(out_valid), 80'd0);
        check_value("abort_ct_kept", 80'(ct), 80'(last_ct));
        spur = 0;
        for (int c = 0; c < 35; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) spur++;
        end
        check_value("abort_no_pulse", 80'(spur), 80'd0);

        // Abort while idle must not block a same-edge accept
        rp = {$urandom(), $urandom()};
        rk = {$urandom(), $urandom(), 16'($urandom())};
        abort = 1'b1;
        send("abort_idle", rp, rk);
        abort = 1'b0;
        wait_done("abort_idle");
        check_value("abort_idle_ct", 80'(ct), 80'(ref_encrypt(rp, rk)));
        last_ct = ct;

        // Abort beats out_ready in DONE
        out_ready = 1'b1;
        abort     = 1'b1;
        @(posedge clk);
        #1;
        abort     = 1'b0;
        out_ready = 1'b0;
        check_value("abort_done_valid", 80'(out_valid), 80'd0);
        check_value("abort_done_in_ready", 80'(in_ready), 80'd1);

        rp = {$urandom(), $urandom()};
        rk = {$urandom(), $urandom(), 16'($urandom())};
        do_vector("post_abort", rp, rk, ref_encrypt(rp, rk));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/present80_enc_core.md
Name: present80_enc_core

Overview:
- Iterative PRESENT-80 block-cipher encryption engine: 64-bit plaintext, 80-bit key, one round per clock.
- Directly consumes the existing key_schedule stage, instantiated once and fed from the internal key register with the round counter as its 5-bit index.
- Sits between the host-side load logic and the ciphertext consumer.
- Valid/ready handshake on both input and output.

Parameters:
- ROUNDS, 31, number of full rounds before final whitening; legal range 1..31; 31 gives standard PRESENT-80.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  plaintext/key offered.
- in_ready  output  1  core idle and able to accept.
- pt  input  64  plaintext.
- key  input  80  cipher key.
- out_valid  output  1  ciphertext available.
- out_ready  input  1  consumer accepts ciphertext.
- ct  output  64  ciphertext.
- abort  input  1  present only with PRESENT_ABORT_EN; see Optional Feature.

Behaviour:
- Reset (async, rst_n low) values:
  - state IDLE, in_ready=1, out_valid=0, ct=0.
  - Internal state/key registers 0; round counter 1.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: S<=pt, K<=key, rc<=1, go RUN.
  - Acceptance edge is E0.
- RUN:
  - in_ready=0.
  - Each edge: S<=pLayer(sLayer(S ^ K[79:16])); K<=key_schedule(K, rc); rc<=rc+1.
  - On the edge where rc==ROUNDS: ct<=S_next ^ K_next[79:16], out_valid<=1, go DONE.
- Latency: out_valid rises after edge E(ROUNDS); it is 31 cycles after acceptance for the default.
- DONE:
  - ct held stable and out_valid held high until out_ready=1 at an edge.
  - Then out_valid<=0, go IDLE.
  - in_ready stays 0 in DONE, so there is no overlap or back-to-back accept in the same edge; the next accept is possible the cycle after the handoff.
- in_valid while busy is ignored; there is no queuing, and the upstream holds its data.
- Once accepted, pt/key inputs are don't-care; the core uses only its internal registers.
- rc is 5 bits and never exceeds 31; wrap is impossible by the ROUNDS range.
- sLayer: the PRESENT 4-bit S-box, applied to all 16 nibbles.
- pLayer: bit i moves to position (16*i) mod 63 for i<63; bit 63 is fixed.
- Reset asserted mid-operation: immediate return to reset values; partial results are discarded and out_valid never pulses.
- All arithmetic is pure bit permutation/XOR; there are no carries.

Optional Feature:
- Macro PRESENT_ABORT_EN.
- Defined:
  - The abort port exists.
  - abort=1 at an edge in RUN or DONE forces IDLE, out_valid=0 and rc=1; ct keeps its last value.
  - abort has priority over out_ready and round progress.
  - abort in IDLE is ignored, and in_valid on the same edge is still accepted.
- Undefined: no abort port; the FSM is exactly as in Behaviour.

Decomposition:
- Package present_pkg:
  - S-box table (16x4).
  - pLayer index function/constant array.
  - Widths BLOCK_W=64, KEY_W=80, RC_W=5.
  - FSM state enum (IDLE/RUN/DONE).
- Sub-module present_round: combinational sLayer+pLayer of the 64-bit state (the round-key XOR stays in the core).
- key_schedule is reused unchanged for the key update; do not duplicate it.

Test Plan:
- pt=0000000000000000, key=0 -> ct=5579C1387B228445, out_valid high exactly 31 cycles after the accept edge.
- pt=0000000000000000, key=FFFFFFFFFFFFFFFFFFFF -> ct=E72C46C0F5945049.
- pt=FFFFFFFFFFFFFFFF, key=0 -> ct=A112FFC72F68417B; then pt=FFFFFFFFFFFFFFFF, key=FFFFFFFFFFFFFFFFFFFF -> ct=3333DCD3213210D2, with the second accept one cycle after the first handoff.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> ct/out_valid stable, in_ready=0, in_valid pulses ignored; release -> single handoff.
- Reset at cycle 15 of RUN -> all outputs at reset values immediately; a fresh vector afterwards yields correct ct.
- With PRESENT_ABORT_EN: abort at cycle 10 of RUN -> IDLE next cycle, no out_valid; a subsequent vector is correct.
